// File: rtl/cps1_vgen_pkg.sv
// Shared timing defaults and pattern codes for the CPS1 synthetic video source.
package cps1_vgen_pkg;

  localparam int DEF_H_TOTAL   = 512;
  localparam int DEF_H_ACTIVE  = 384;
  localparam int DEF_H_START   = 64;
  localparam int DEF_H_SYNCLEN = 36;
  localparam int DEF_V_TOTAL   = 262;
  localparam int DEF_V_ACTIVE  = 224;
  localparam int DEF_V_START   = 16;
  localparam int DEF_V_SYNCLEN = 3;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_WHITE = 2'd3;

  function automatic logic [3:0] nib(input logic on);
    return on ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/cps1_vgen_pattern.sv
// Combinational pattern generator: (pattern, x, y, bar index) -> RGBF nibbles.
module cps1_vgen_pattern
  import cps1_vgen_pkg::*;
(
  input  logic [1:0] pattern,
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic [2:0] bar,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [3:0] f
);

  logic unused_bits;
  assign unused_bits = ^{x[8:6], x[1:0], y[8:4], y[2:0]};

  always_comb begin
    r = 4'h0;
    g = 4'h0;
    b = 4'h0;
    f = 4'h0;
    case (pattern)
      PAT_BARS: begin
        r = nib(bar[2]);
        g = nib(bar[1]);
        b = nib(bar[0]);
        f = 4'hF;
      end
      PAT_GRAD: begin
        r = x[5:2];
        g = x[5:2];
        b = x[5:2];
        f = 4'hF;
      end
      PAT_CHECK: begin
        r = nib(x[3] ^ y[3]);
        g = nib(x[3] ^ y[3]);
        b = nib(x[3] ^ y[3]);
        f = nib(x[3] ^ y[3]);
      end
      default: begin
        r = 4'hF;
        g = 4'hF;
        b = 4'hF;
        f = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/cps1_video_gen.sv
// CPS1-style synthetic RGBF + composite sync source at the PCLK2x rate.
// Define CPS1_VGEN_SCROLL_EN to scroll the pattern horizontally by 1 px per frame.
module cps1_video_gen
  import cps1_vgen_pkg::*;
#(
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_START   = DEF_H_START,
  parameter int H_SYNCLEN = DEF_H_SYNCLEN,
  parameter int V_TOTAL   = DEF_V_TOTAL,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_START   = DEF_V_START,
  parameter int V_SYNCLEN = DEF_V_SYNCLEN
) (
  input  logic       PCLK2x_i,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [1:0] pattern_sel_i,
  output logic [3:0] R_o,
  output logic [3:0] G_o,
  output logic [3:0] B_o,
  output logic [3:0] F_o,
  output logic       CSYNC_o,
  output logic       DE_o,
  output logic       frame_start_o
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic           phase_reg;
  logic [HW-1:0]  hcnt_reg, hcnt_next;
  logic [VW-1:0]  vcnt_reg;
  logic [BPW-1:0] bar_px_reg, bar_px_init;
  logic [2:0]     bar_idx_reg, bar_idx_init;
  logic [1:0]     pat_reg;
  logic [3:0]     r_reg, g_reg, b_reg, f_reg;
  logic           csync_reg, de_reg, frame_start_reg;

  logic           h_wrap, v_wrap, frame_start_now, active, hsync_zone, vsync_line;
  logic [8:0]     x_raw, y_raw, x_pat;
  logic [3:0]     pat_r, pat_g, pat_b, pat_f;

  assign h_wrap          = (int'(hcnt_reg) == H_TOTAL - 1);
  assign v_wrap          = (int'(vcnt_reg) == V_TOTAL - 1);
  assign hcnt_next       = h_wrap ? '0 : hcnt_reg + 1'b1;
  assign frame_start_now = !phase_reg && (hcnt_reg == '0) && (vcnt_reg == '0);
  assign active          = (int'(hcnt_reg) >= H_START) && (int'(hcnt_reg) < H_START + H_ACTIVE) &&
                           (int'(vcnt_reg) >= V_START) && (int'(vcnt_reg) < V_START + V_ACTIVE);
  assign hsync_zone      = (int'(hcnt_reg) < H_SYNCLEN);
  assign vsync_line      = (int'(vcnt_reg) < V_SYNCLEN);
  assign x_raw           = 9'(int'(hcnt_reg) - H_START);
  assign y_raw           = 9'(int'(vcnt_reg) - V_START);

`ifdef CPS1_VGEN_SCROLL_EN
  // The offset carries its own bar position so lines can start mid-bar without a divider.
  logic [8:0]     offset_reg;
  logic [BPW-1:0] off_px_reg;
  logic [2:0]     off_idx_reg;
  logic [9:0]     x_sum;

  always_ff @(posedge PCLK2x_i) begin
    if (reset) begin
      offset_reg  <= '0;
      off_px_reg  <= '0;
      off_idx_reg <= '0;
    end else if (frame_start_now) begin
      offset_reg <= (int'(offset_reg) == H_ACTIVE - 1) ? '0 : offset_reg + 1'b1;
      if (int'(off_px_reg) == BAR_W - 1) begin
        off_px_reg  <= '0;
        off_idx_reg <= off_idx_reg + 1'b1;
      end else begin
        off_px_reg <= off_px_reg + 1'b1;
      end
    end
  end

  assign x_sum        = {1'b0, x_raw} + {1'b0, offset_reg};
  assign x_pat        = (int'(x_sum) >= H_ACTIVE) ? 9'(int'(x_sum) - H_ACTIVE) : x_sum[8:0];
  assign bar_px_init  = off_px_reg;
  assign bar_idx_init = off_idx_reg;
`else
  assign x_pat        = x_raw;
  assign bar_px_init  = '0;
  assign bar_idx_init = '0;
`endif

  always_ff @(posedge PCLK2x_i) begin
    if (reset) begin
      phase_reg   <= 1'b0;
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
    end else begin
      phase_reg <= ~phase_reg;
      if (phase_reg) begin
        hcnt_reg <= hcnt_next;
        if (h_wrap)
          vcnt_reg <= v_wrap ? '0 : vcnt_reg + 1'b1;
        // Bar position is reloaded just before the first active pixel of each line.
        if (int'(hcnt_next) == H_START) begin
          bar_px_reg  <= bar_px_init;
          bar_idx_reg <= bar_idx_init;
        end else if (int'(bar_px_reg) == BAR_W - 1) begin
          bar_px_reg  <= '0;
          bar_idx_reg <= bar_idx_reg + 1'b1;
        end else begin
          bar_px_reg <= bar_px_reg + 1'b1;
        end
      end
    end
  end

  cps1_vgen_pattern u_pattern (
    .pattern (pat_reg),
    .x       (x_pat),
    .y       (y_raw),
    .bar     (bar_idx_reg),
    .r       (pat_r),
    .g       (pat_g),
    .b       (pat_b),
    .f       (pat_f)
  );

  always_ff @(posedge PCLK2x_i) begin
    if (reset) begin
      r_reg           <= '0;
      g_reg           <= '0;
      b_reg           <= '0;
      f_reg           <= '0;
      csync_reg       <= 1'b1;
      de_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
      pat_reg         <= PAT_BARS;
    end else begin
      frame_start_reg <= frame_start_now;
      if (!phase_reg) begin
        csync_reg <= vsync_line ? hsync_zone : !hsync_zone;
        de_reg    <= active;
        r_reg     <= (active && enable_i) ? pat_r : 4'h0;
        g_reg     <= (active && enable_i) ? pat_g : 4'h0;
        b_reg     <= (active && enable_i) ? pat_b : 4'h0;
        f_reg     <= (active && enable_i) ? pat_f : 4'h0;
        if (frame_start_now)
          pat_reg <= pattern_sel_i;
      end
    end
  end

  assign R_o           = r_reg;
  assign G_o           = g_reg;
  assign B_o           = b_reg;
  assign F_o           = f_reg;
  assign CSYNC_o       = csync_reg;
  assign DE_o          = de_reg;
  assign frame_start_o = frame_start_reg;

endmodule
